// File: rtl/mediana_rank_if.sv
// rtl/mediana_rank_if.sv - load/result bundle between a sort requester and mediana_rank
interface mediana_rank_if #(
    parameter int WIDTH = 8,
    parameter int N     = 9,
    parameter int RW    = $clog2(N)
);
    logic                 start;
    logic [N*WIDTH-1:0]   entrada;
    logic [RW-1:0]        rank;
    logic                 modo_signed;
    logic                 busy;
    logic                 flag;
    logic [WIDTH-1:0]     saida;
    logic [N*WIDTH-1:0]   ordenada;
    logic [RW:0]          ciclos;

    modport master (
        output start, entrada, rank, modo_signed,
        input  busy, flag, saida, ordenada, ciclos
    );

    modport slave (
        input  start, entrada, rank, modo_signed,
        output busy, flag, saida, ordenada, ciclos
    );
endinterface

// File: rtl/mediana_rank.sv
// rtl/mediana_rank.sv - odd-even transposition sorter with rank select and early exit
module mediana_rank #(
    parameter int WIDTH = 8,
    parameter int N     = 9,
    parameter int RW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    mediana_rank_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SORT, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_data [N];
    logic [WIDTH-1:0]   w_next [N];
    logic [RW-1:0]      r_phase;
    logic [RW-1:0]      r_rank;
    logic [RW-1:0]      w_rank_clamped;
    logic               r_signed;
    logic               r_prev_swap;
    logic               w_swap;
    logic               w_exit;
    logic               w_load;
    logic [RW:0]        r_ciclos;
    logic [WIDTH-1:0]   r_saida;
    logic [N*WIDTH-1:0] r_ordenada;
    logic [N*WIDTH-1:0] w_next_flat;

    function automatic logic f_greater(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic             sgn);
        if (sgn) return $signed(a) > $signed(b);
        else     return a > b;
    endfunction

    // A start is only honoured when no sort is in flight
    assign w_load = bus.start && (r_state != S_SORT);

    // Out-of-range ranks select the largest element
    assign w_rank_clamped = (int'(bus.rank) >= N) ? RW'(N - 1) : bus.rank;

    // One compare-exchange phase: even phases pair (0,1),(2,3)..., odd phases (1,2),(3,4)...
    always_comb begin
        w_swap = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_next[i] = r_data[i];
        end
        for (int i = 0; i < N - 1; i++) begin
            if ((i % 2) == int'(r_phase[0])) begin
                if (f_greater(r_data[i], r_data[i+1], r_signed)) begin
                    w_next[i]   = r_data[i+1];
                    w_next[i+1] = r_data[i];
                    w_swap      = 1'b1;
                end
            end
        end
    end

    // Two quiet phases in a row (one of each parity) prove the vector is sorted
    assign w_exit = (r_phase == RW'(N - 1)) ||
                    ((r_phase != '0) && !w_swap && !r_prev_swap);

    // Flatten the post-phase vector, index 0 in the low bits
    always_comb begin
        w_next_flat = '0;
        for (int i = 0; i < N; i++) begin
            w_next_flat[i*WIDTH +: WIDTH] = w_next[i];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_SORT;
            S_SORT:  if (w_exit)    w_state_next = S_DONE;
            S_DONE:  if (bus.start) w_state_next = S_SORT;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State-decoded status outputs
    always_comb begin
        bus.busy = (r_state == S_SORT);
        bus.flag = (r_state == S_DONE);
    end

    // Datapath: capture on load, one phase per SORT cycle, publish results on exit
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) r_data[i] <= '0;
            r_phase     <= '0;
            r_rank      <= '0;
            r_signed    <= 1'b0;
            r_prev_swap <= 1'b0;
            r_ciclos    <= '0;
            r_saida     <= '0;
            r_ordenada  <= '0;
        end else if (w_load) begin
            for (int i = 0; i < N; i++) r_data[i] <= bus.entrada[i*WIDTH +: WIDTH];
            r_phase     <= '0;
            r_rank      <= w_rank_clamped;
            r_signed    <= bus.modo_signed;
            r_prev_swap <= 1'b0;
            r_ciclos    <= '0;
        end else if (r_state == S_SORT) begin
            for (int i = 0; i < N; i++) r_data[i] <= w_next[i];
            r_phase     <= r_phase + 1'b1;
            r_prev_swap <= w_swap;
            r_ciclos    <= r_ciclos + 1'b1;
            if (w_exit) begin
                r_saida    <= w_next[r_rank];
                r_ordenada <= w_next_flat;
            end
        end
    end

    assign bus.saida    = r_saida;
    assign bus.ordenada = r_ordenada;
    assign bus.ciclos   = r_ciclos;
endmodule
